nexthop_table: RTL and testbench
================================

# nexthop_table

Per-input-channel next-hop store for the NOC arbiter. It holds one registered output-port address per input channel, latched when a head flit is routed and held until the packet's tail releases it. It also presents a decoded per-channel request vector to the output arbiters. The block is the parametrised, multi-channel successor of the single-entry next-hop register, and adds lock/release semantics, range checking, sticky error flags and an occupancy count.

## Interface
- NUM_CH, default 5: number of input channels (entries); ≥1.
- ADDR_WIDTH, default 3: width of a next-hop address.
- NUM_PORTS, default 5: number of valid output ports. NUM_PORTS ≤ 2^ADDR_WIDTH (elaboration-time assertion).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- nht_write_i  in  NUM_CH  per-channel load strobe (head flit routed).
- nht_address_i  in  NUM_CH*ADDR_WIDTH  packed addresses; channel c at [c*ADDR_WIDTH +: ADDR_WIDTH].
- nht_release_i  in  NUM_CH  per-channel release strobe (tail flit forwarded).
- nht_address_o  out  NUM_CH*ADDR_WIDTH  stored address per channel, same packing.
- nht_valid_o  out  NUM_CH  entry locked/valid.
- nht_req_o  out  NUM_CH*NUM_PORTS  one-hot request per channel; channel c at [c*NUM_PORTS +: NUM_PORTS].
- nht_busy_count_o  out  $clog2(NUM_CH+1)  number of valid entries.
- nht_error_o  out  NUM_CH  sticky per-channel protocol error.

## Operation
- Each channel c is independent. Its state is addr[c], valid[c] and err[c].
- "In range" means nht_address_i slice < NUM_PORTS.
- Per-channel next-state at the clock edge, in priority order:
  - write=1, in range, and (valid=0 or release=1): addr ← input, valid ← 1. This covers back-to-back packets (release+write in the same cycle keeps the entry valid with the new address).
  - write=1, out of range: addr unchanged; err ← 1; valid ← 0 if release=1, else unchanged.
  - write=1, valid=1, release=0: write ignored, addr/valid unchanged, err ← 1 (overwrite of a locked entry).
  - write=0, release=1: valid ← 0; addr retained (don't-care for consumers). Releasing an invalid entry is a no-op and sets no error.
  - Otherwise: hold.
- err[c] is sticky and cleared only by reset.
- nht_req_o[c*NUM_PORTS + p] = valid[c] && (addr[c] == p). It is combinational from registered state, so it is all-zero for invalid entries.
- nht_busy_count_o = popcount(valid), derived combinationally from registered valid.
- No cross-channel interaction. Any mix of channels may write or release in the same cycle.

## Timing
- Reset (reset=0, asynchronous assert) forces immediately:
  - nht_address_o = 0
  - nht_valid_o = 0
  - nht_req_o = 0
  - nht_busy_count_o = 0
  - nht_error_o = 0
- Deassertion is synchronous to clk (externally synchronised). The first update takes effect at the first rising edge with reset=1.
- Reset asserted mid-packet drops all locks; no release is required afterwards.
- Latency: a write or release sampled at edge N is visible on all outputs after edge N. No combinational path from any input to any output.
- Count range 0..NUM_CH; no wrap possible.
- No back-pressure or handshake. Strobes are single-cycle qualifiers; holding a strobe high repeats its effect each cycle. A held write on a valid entry sets err on the second cycle.

## Test plan
- Reset: assert reset=0 mid-cycle with entries valid → all outputs 0 immediately (asynchronous), before the next clk edge.
- Basic lock (NUM_CH=5, ADDR_WIDTH=3, NUM_PORTS=5): write ch2 with addr 3 → next cycle:
  - nht_address_o[8:6]=3, nht_valid_o=5'b00100
  - nht_req_o[14:10]=5'b01000, count=1, errors 0.
- Overwrite protection: ch2 valid with addr 3; write ch2 with addr 1, no release → addr stays 3, valid stays 1, nht_error_o[2]=1 and remains 1 through later cycles.
- Back-to-back: ch0 valid with addr 4; same-cycle release+write addr 0 → next cycle addr 0, valid 1, nht_req_o[4:0]=5'b00001, count unchanged, no error.
- Range check: write ch4 with addr 6 → valid[4]=0, req slice 0, nht_error_o[4]=1. Release ch1 while invalid → no change, no error.
- Concurrency: all 5 channels write distinct in-range addresses in one cycle → count=5. Next cycle release ch1 and ch3 → count=3, nht_valid_o=5'b10101.

Source files
------------

// File: rtl/nexthop_table.sv
// Per-input-channel next-hop store: locks an output-port address on a head flit,
// holds it until the tail releases it, and presents decoded requests to the arbiters.
module nexthop_table #(
  parameter int NUM_CH     = 5,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_PORTS  = 5,
  localparam int CNT_W     = $clog2(NUM_CH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              nht_write_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   nht_address_i,
  input  logic [NUM_CH-1:0]              nht_release_i,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   nht_address_o,
  output logic [NUM_CH-1:0]              nht_valid_o,
  output logic [NUM_CH*NUM_PORTS-1:0]    nht_req_o,
  output logic [CNT_W-1:0]               nht_busy_count_o,
  output logic [NUM_CH-1:0]              nht_error_o
);

  if (NUM_PORTS > (2 ** ADDR_WIDTH)) begin : g_bad_ports
    $error("nexthop_table: NUM_PORTS exceeds the address space of ADDR_WIDTH");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("nexthop_table: NUM_CH must be at least 1");
  end

  localparam logic [ADDR_WIDTH:0] NUM_PORTS_W = (ADDR_WIDTH + 1)'(NUM_PORTS);

  logic [ADDR_WIDTH-1:0] addr_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_CH];
  logic [NUM_CH-1:0]     valid_q, valid_d;
  logic [NUM_CH-1:0]     err_q, err_d;

  logic [ADDR_WIDTH-1:0] wr_addr [NUM_CH];
  logic [NUM_CH-1:0]     in_range;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_addr[c]  = nht_address_i[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range[c] = {1'b0, wr_addr[c]} < NUM_PORTS_W;
    assign nht_address_o[c*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[c];
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
    valid_d = valid_q;
    err_d   = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      addr_d[c] = addr_q[c];
      if (nht_write_i[c]) begin
        if (!in_range[c]) begin
          err_d[c] = 1'b1;
          if (nht_release_i[c]) valid_d[c] = 1'b0;
        end else if (!valid_q[c] || nht_release_i[c]) begin
          // Release+write in one cycle hands the entry straight to the next packet.
          addr_d[c]  = wr_addr[c];
          valid_d[c] = 1'b1;
        end else begin
          err_d[c] = 1'b1;
        end
      end else if (nht_release_i[c]) begin
        valid_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the address storage is reset as well, since nht_address_o must read 0 during reset.
      for (int c = 0; c < NUM_CH; c++) addr_q[c] <= '0;
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      addr_q  <= addr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    nht_req_o        = '0;
    nht_busy_count_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        nht_req_o[c*NUM_PORTS + p] = valid_q[c] && (addr_q[c] == ADDR_WIDTH'(p));
      end
      nht_busy_count_o = nht_busy_count_o + CNT_W'(valid_q[c]);
    end
  end

  assign nht_valid_o = valid_q;
  assign nht_error_o = err_q;

endmodule

// File: tb/tb_nexthop_table.sv
// Scoreboard bench for nexthop_table: stimulus pushes expected outputs from a
// behavioural model; a monitor pops and compares after every sampled edge.
module tb_nexthop_table;

  localparam int NCH = 5;
  localparam int AW  = 3;
  localparam int NP  = 5;
  localparam int CW  = $clog2(NCH + 1);

  logic                clk;
  logic                reset;
  logic [NCH-1:0]      wr;
  logic [NCH*AW-1:0]   addr_in;
  logic [NCH-1:0]      rel;
  logic [NCH*AW-1:0]   addr_out;
  logic [NCH-1:0]      valid_out;
  logic [NCH*NP-1:0]   req_out;
  logic [CW-1:0]       cnt_out;
  logic [NCH-1:0]      err_out;

  nexthop_table #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) dut (
    .clk              (clk),
    .reset            (reset),
    .nht_write_i      (wr),
    .nht_address_i    (addr_in),
    .nht_release_i    (rel),
    .nht_address_o    (addr_out),
    .nht_valid_o      (valid_out),
    .nht_req_o        (req_out),
    .nht_busy_count_o (cnt_out),
    .nht_error_o      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*AW-1:0] addr;
    logic [NCH-1:0]    valid;
    logic [NCH*NP-1:0] req;
    logic [CW-1:0]     cnt;
    logic [NCH-1:0]    err;
  } exp_t;

  exp_t sb[$];

  // Reference model: one record per channel.
  int m_addr  [NCH];
  bit m_valid [NCH];
  bit m_err   [NCH];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_addr[c] = 0; m_valid[c] = 0; m_err[c] = 0;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.addr = '0; e.valid = '0; e.req = '0; e.cnt = '0; e.err = '0;
    for (int c = 0; c < NCH; c++) begin
      e.addr[c*AW +: AW] = AW'(m_addr[c]);
      e.valid[c] = m_valid[c];
      e.err[c]   = m_err[c];
      if (m_valid[c]) begin
        e.req[c*NP + m_addr[c]] = 1'b1;
        e.cnt = e.cnt + 1'b1;
      end
    end
    return e;
  endfunction

  // Drive one cycle of strobes, advance the model, push what must appear after the edge.
  task automatic step(input logic [NCH-1:0] w, input logic [NCH*AW-1:0] a, input logic [NCH-1:0] r);
    logic [NCH*AW-1:0] av;
    @(negedge clk);
    wr = w; addr_in = a; rel = r;
    av = a;
    for (int c = 0; c < NCH; c++) begin
      int  x;
      bit  bad, locked, load;
      x      = int'(av[c*AW +: AW]);
      bad    = w[c] && (x >= NP);
      locked = w[c] && !bad && m_valid[c] && !r[c];
      load   = w[c] && !bad && !locked;
      if (bad || locked) m_err[c] = 1;
      if (load) begin
        m_addr[c]  = x;
        m_valid[c] = 1;
      end else if (r[c]) begin
        m_valid[c] = 0;
      end
    end
    sb.push_back(model_outputs());
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next clock edge.
  task automatic async_reset();
    @(negedge clk);
    wr = '0; addr_in = '0; rel = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_addr",  32'(addr_out),  32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_req",   32'(req_out),   32'd0);
    check("rst_count", 32'(cnt_out),   32'd0);
    check("rst_err",   32'(err_out),   32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_addr",  32'(addr_out),  32'(e.addr));
      check("sb_valid", 32'(valid_out), 32'(e.valid));
      check("sb_req",   32'(req_out),   32'(e.req));
      check("sb_count", 32'(cnt_out),   32'(e.cnt));
      check("sb_err",   32'(err_out),   32'(e.err));
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; wr = '0; addr_in = '0; rel = '0;
    model_clear();
    #1 reset = 1'b0;
    #2;
    check("init_valid", 32'(valid_out), 32'd0);
    check("init_req",   32'(req_out),   32'd0);
    check("init_count", 32'(cnt_out),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic lock: ch2 -> port 3
    step(5'b00100, 15'(3) << 6, 5'b00000);
    after_edge();
    check("lock_addr",  32'(addr_out[8:6]),  32'd3);
    check("lock_valid", 32'(valid_out),      32'b00100);
    check("lock_req",   32'(req_out[14:10]), 32'b01000);
    check("lock_count", 32'(cnt_out),        32'd1);
    check("lock_err",   32'(err_out),        32'd0);

    // Overwrite of a locked entry is ignored and flagged
    step(5'b00100, 15'(1) << 6, 5'b00000);
    after_edge();
    check("ovw_addr",  32'(addr_out[8:6]), 32'd3);
    check("ovw_valid", 32'(valid_out[2]),  32'd1);
    check("ovw_err",   32'(err_out[2]),    32'd1);
    step('0, '0, '0);
    step('0, '0, '0);
    after_edge();
    check("ovw_err_sticky", 32'(err_out[2]), 32'd1);

    // Back-to-back packet on ch0
    step(5'b00001, 15'd4, 5'b00000);
    step(5'b00001, 15'd0, 5'b00001);
    after_edge();
    check("b2b_addr",  32'(addr_out[2:0]), 32'd0);
    check("b2b_valid", 32'(valid_out[0]),  32'd1);
    check("b2b_req",   32'(req_out[4:0]),  32'b00001);
    check("b2b_count", 32'(cnt_out),       32'd2);
    check("b2b_err",   32'(err_out[0]),    32'd0);

    // Out-of-range write on ch4, then release of an invalid ch1
    step(5'b10000, 15'(6) << 12, 5'b00000);
    after_edge();
    check("rng_valid", 32'(valid_out[4]),    32'd0);
    check("rng_req",   32'(req_out[24:20]),  32'd0);
    check("rng_err",   32'(err_out[4]),      32'd1);
    step(5'b00000, '0, 5'b00010);
    after_edge();
    check("relinv_valid", 32'(valid_out[1]), 32'd0);
    check("relinv_err",   32'(err_out[1]),   32'd0);

    // Reset with locks held drops everything
    async_reset();

    // All channels at once, then partial release
    step(5'b11111, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 5'b00000);
    after_edge();
    check("all_count", 32'(cnt_out), 32'd5);
    step(5'b00000, '0, 5'b01010);
    after_edge();
    check("part_count", 32'(cnt_out),   32'd3);
    check("part_valid", 32'(valid_out), 32'b10101);

    // Randomised traffic, with periodic resets so sticky errors don't saturate
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0]    w, r;
      logic [NCH*AW-1:0] a;
      w = NCH'($urandom) & NCH'($urandom);
      r = NCH'($urandom) & NCH'($urandom);
      a = '0;
      for (int c = 0; c < NCH; c++) begin
        a[c*AW +: AW] = ($urandom_range(0, 7) < 6) ? AW'($urandom_range(0, NP - 1))
                                                   : AW'($urandom_range(NP, 7));
      end
      step(w, a, r);
      if (i % 60 == 59) async_reset();
    end

    after_edge();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
